regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Round-robin arbiter that shares the register file's single write port among NUM_REQ writeback requesters (ALU, load unit, debug/CSR path).
- Each requester has a valid/ready handshake.
- The granted write is registered and driven onto the register file's write port one cycle after acceptance.
- Supports burst locking, a global stall, a synchronous flush, and silent dropping of x0 writes.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester write request.
- req_lock  input  NUM_REQ  requester i asks to keep the grant on the next cycle.
- req_addr  input  NUM_REQ*ADDR_W  flattened destination addresses; slice i = bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  flattened write data.
- req_ready  output  NUM_REQ  one-hot (or zero) grant/accept this cycle.
- stall  input  1  blocks all new grants.
- flush  input  1  cancels the registered write stage.
- wr_en  output  1  register file write enable.
- wr_addr  output  ADDR_W  register file write address.
- wr_data  output  DATA_W  register file write data.
- drop_cnt  output  8  saturating count of accepted x0 writes.

Behaviour:
- Reset (async) clears all state:
  - wr_en=0, wr_addr=0, wr_data=0, drop_cnt=0.
  - rr_ptr=0, lock_owner invalid.
  - req_ready=0 while reset is high.
- Handshake:
  - Transfer for i occurs when req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid, stall, rr_ptr and lock state.
  - At most one bit of req_ready is set.
  - req_ready never asserts for a requester with req_valid=0.
- Arbitration (when stall=0 and no active lock):
  - Search from rr_ptr upward, modulo NUM_REQ; the first valid requester wins.
  - On a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Lock state machine, states UNLOCKED and LOCKED(owner):
  - UNLOCKED -> LOCKED(i) when i is granted with req_lock[i]=1.
  - In LOCKED(i):
    - Only i may be granted.
    - If req_valid[i]=1: grant i; stay locked if req_lock[i]=1, otherwise go to UNLOCKED.
    - If req_valid[i]=0: no grant, go to UNLOCKED immediately; the others compete from the next cycle.
  - rr_ptr is not updated during locked grants except the final one, which sets rr_ptr=(i+1) mod NUM_REQ.
- Stall:
  - stall=1 forces req_ready=0.
  - Lock state and rr_ptr hold.
  - The output stage still updates: wr_en <= 0 next cycle.
- Output stage, 1-cycle latency:
  - On cycle N, a transfer with addr!=0: at cycle N+1, wr_en=1, wr_addr=addr, wr_data=data.
  - No transfer: wr_en <= 0; wr_addr/wr_data hold their previous values.
  - Transfer with addr==0: accepted (ready=1, pointer/lock update normally), wr_en <= 0, drop_cnt += 1, saturating at 255.
- Flush:
  - flush=1 at a clock edge forces wr_en <= 0 regardless of the same-cycle transfer, so that transfer is discarded.
  - flush also clears the lock (-> UNLOCKED).
  - rr_ptr still advances for the same-cycle grant.
  - drop_cnt is unchanged by a flushed x0 write.
- Flush and stall together: stall wins for grants; flush clears the lock.
- Reset mid-burst: lock is lost; after deassertion, arbitration restarts from rr_ptr=0.
- Throughput: one write per cycle sustained. Back-to-back grants to different requesters need no bubble.

Test Plan:
- Reset, then req_valid=3'b111, addrs 1/2/3, data 0xA/0xB/0xC, held 3 cycles -> grants 0,1,2 in order. Cycles 2-4: wr_en=1 with (1,0xA),(2,0xB),(3,0xC).
- rr_ptr=1, req_valid=3'b101 -> requester 2 granted first, then 0; rr_ptr ends at 1.
- Requester 0: req_lock=1 for 3 cycles, then lock=0 on the 4th, while requester 1 is continuously valid -> requester 0 granted 4 consecutive cycles, requester 1 granted on the 5th.
- Requester 1 writes addr 0, data 0xFFFF -> req_ready[1]=1, wr_en stays 0 next cycle, drop_cnt increments 0->1. Next write to addr 5 produces wr_en=1.
- Assert stall with all requesters valid for 2 cycles -> req_ready=0, wr_en=0 from the next cycle, rr_ptr unchanged. Then assert flush in the same cycle as a grant to addr 7 -> no wr_en for addr 7, lock cleared.
- Assert reset asynchronously mid-cycle during a locked burst -> wr_en drops to 0 immediately. After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin sharing of the single write
// port among NUM_REQ requesters, with burst locking, stall, flush, and
// silent dropping of x0 writes (counted in drop_cnt).

// Per-requester front end: decides whether this requester may win this cycle
// and flags writes to x0.
module regfile_wb_lane #(
  parameter int ADDR_W = 5
) (
  input  logic              valid,
  input  logic              locked,
  input  logic              owner_hit,
  input  logic              block,
  input  logic [ADDR_W-1:0] addr,
  output logic              eligible,
  output logic              is_x0
);

  // While a burst is locked only the owner may compete; stall/reset block all.
  always_comb begin
    eligible = valid && !block && (!locked || owner_hit);
    is_x0    = (addr == '0);
  end

endmodule

module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [7:0]                drop_cnt
);

  localparam int PW = $clog2(NUM_REQ);

  typedef struct packed {
    logic              x0;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_a;
  logic [NUM_REQ-1:0]             elig;
  logic [NUM_REQ-1:0]             x0_a;

  logic [PW-1:0] rr_ptr;
  logic          locked;
  logic [PW-1:0] lock_owner;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      gidx;
  logic               xfer;
  logic               found;
  int                 idx;
  wb_req_t            sel;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
      assign data_a[g] = req_data[g*DATA_W +: DATA_W];
      regfile_wb_lane #(.ADDR_W(ADDR_W)) u_lane (
        .valid     (req_valid[g]),
        .locked    (locked),
        .owner_hit (lock_owner == PW'(g)),
        .block     (stall | reset),
        .addr      (addr_a[g]),
        .eligible  (elig[g]),
        .is_x0     (x0_a[g])
      );
    end
  endgenerate

  // Rotating-priority search starting at rr_ptr; when locked only the owner
  // is eligible, so the same search yields the locked grant.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx[PW-1:0];
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = found;

  // Selected request fields, muxed by the winning index.
  always_comb begin
    sel.x0   = x0_a[gidx];
    sel.lock = req_lock[gidx];
    sel.addr = addr_a[gidx];
    sel.data = data_a[gidx];
  end

  // Round-robin pointer: moves past every winner, holds otherwise. Within a
  // locked burst the winner is always the owner, so this is idempotent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rr_ptr <= '0;
    else if (xfer) rr_ptr <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
  end

  // Lock state: flush always unlocks, stall freezes, otherwise the owner
  // keeps the lock only while it stays valid with req_lock set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked     <= 1'b0;
      lock_owner <= '0;
    end else if (flush) begin
      locked <= 1'b0;
    end else if (!stall) begin
      if (locked) begin
        if (!(req_valid[lock_owner] && req_lock[lock_owner])) locked <= 1'b0;
      end else if (xfer && sel.lock) begin
        locked     <= 1'b1;
        lock_owner <= gidx;
      end
    end
  end

  // Registered write stage; flushed and x0 transfers never reach the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer && !flush && !sel.x0;
      if (xfer && !flush && !sel.x0) begin
        wr_addr <= sel.addr;
        wr_data <= sel.data;
      end
    end
  end

  // Saturating count of accepted, non-flushed x0 writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             drop_cnt <= '0;
    else if (xfer && !flush && sel.x0 && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_lock, req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              stall, flush;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [7:0]        drop_cnt;

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: what the spec says the block remembers.
  int          m_rr, m_own, m_drop;
  bit          m_lk, m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [N-1:0]  last_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic m_reset();
    m_rr = 0; m_own = 0; m_lk = 0; m_we = 0; m_wa = '0; m_wd = '0; m_drop = 0;
  endtask

  // Who the spec says is granted right now.
  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int i;
    r = '0;
    if (reset || stall) return r;
    if (m_lk) begin
      if (req_valid[m_own]) r[m_own] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Apply one clock edge to the model given the grant seen this cycle.
  task automatic m_edge(input logic [N-1:0] gr);
    int gi;
    logic [AW-1:0] a;
    gi = -1;
    for (int i = 0; i < N; i++) if (gr[i]) gi = i;
    if (gi >= 0) m_rr = (gi + 1) % N;
    if (flush) m_lk = 0;
    else if (!stall) begin
      if (m_lk) m_lk = req_valid[m_own] && req_lock[m_own];
      else if (gi >= 0 && req_lock[gi]) begin m_lk = 1; m_own = gi; end
    end
    if (gi >= 0 && !flush) begin
      a = req_addr[gi*AW +: AW];
      if (a != 0) begin
        m_we = 1; m_wa = a; m_wd = req_data[gi*DW +: DW];
      end else begin
        m_we = 0;
        if (m_drop < 255) m_drop++;
      end
    end else m_we = 0;
  endtask

  // One cycle: inputs already driven at posedge+1; compare at +2, then edge.
  task automatic step();
    logic [N-1:0] exp_r;
    #1;
    exp_r = m_ready();
    last_ready = req_ready;
    chk("ready", req_ready, exp_r);
    chk("wr_en", wr_en, m_we);
    if (m_we) begin
      chk("wr_addr", wr_addr, m_wa);
      chk("wr_data", wr_data, m_wd);
    end
    chk("drop_cnt", drop_cnt, m_drop);
    @(posedge clk);
    m_edge(exp_r);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic s, input logic f);
    req_valid = v; req_lock = l; stall = s; flush = f;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    m_reset();
    reset = 1'b1;
    drive(3'b111, 3'b000, 1'b0, 1'b0);
    set_req(0, 5'd1, 32'hA); set_req(1, 5'd2, 32'hB); set_req(2, 5'd3, 32'hC);
    #7;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_drop", drop_cnt, 8'd0);
    req_valid = '0;
    #15 reset = 1'b0;
    @(posedge clk); #1;

    // Round robin 0,1,2 with pipelined writes.
    drive(3'b111, 3'b000, 1'b0, 1'b0);
    step(); chk("rr_g0", last_ready, 3'b001); chk("rr_w1", {wr_en, wr_addr, wr_data[7:0]}, {1'b1, 5'd1, 8'hA});
    step(); chk("rr_g1", last_ready, 3'b010); chk("rr_w2", {wr_en, wr_addr, wr_data[7:0]}, {1'b1, 5'd2, 8'hB});
    step(); chk("rr_g2", last_ready, 3'b100); chk("rr_w3", {wr_en, wr_addr, wr_data[7:0]}, {1'b1, 5'd3, 8'hC});

    // rr_ptr=1 then 101: requester 2 first, then 0.
    drive(3'b001, 3'b000, 1'b0, 1'b0); step();
    drive(3'b101, 3'b000, 1'b0, 1'b0);
    step(); chk("rr101_a", last_ready, 3'b100);
    step(); chk("rr101_b", last_ready, 3'b001);

    // Lock burst: move rr_ptr to 0, then requester 0 locks for 4 grants.
    drive(3'b100, 3'b000, 1'b0, 1'b0); step();
    drive(3'b011, 3'b001, 1'b0, 1'b0);
    step(); chk("lock_g1", last_ready, 3'b001);
    step(); chk("lock_g2", last_ready, 3'b001);
    step(); chk("lock_g3", last_ready, 3'b001);
    req_lock = 3'b000;
    step(); chk("lock_g4", last_ready, 3'b001);
    step(); chk("lock_g5", last_ready, 3'b010);

    // x0 write is accepted but dropped and counted.
    set_req(1, 5'd0, 32'hFFFF);
    drive(3'b010, 3'b000, 1'b0, 1'b0);
    step(); chk("x0_ready", last_ready, 3'b010);
    chk("x0_wr_en", wr_en, 1'b0); chk("x0_drop", drop_cnt, 8'd1);
    set_req(1, 5'd5, 32'h55);
    step(); chk("x5_wr", {wr_en, wr_addr}, {1'b1, 5'd5});

    // Stall blocks grants; pointer holds (still at 2).
    drive(3'b111, 3'b000, 1'b1, 1'b0);
    step(); chk("stall_r1", last_ready, 3'b000); chk("stall_we1", wr_en, 1'b0);
    step(); chk("stall_r2", last_ready, 3'b000);
    drive(3'b111, 3'b000, 1'b0, 1'b0);
    step(); chk("post_stall", last_ready, 3'b100);

    // Flush discards the same-cycle write to addr 7 and drops the lock.
    set_req(0, 5'd7, 32'h77);
    drive(3'b001, 3'b001, 1'b0, 1'b1);
    step(); chk("flush_g", last_ready, 3'b001); chk("flush_we", wr_en, 1'b0);
    drive(3'b011, 3'b000, 1'b0, 1'b0);
    step(); chk("flush_unlk", last_ready, 3'b010);

    // Async reset in the middle of a locked burst.
    set_req(0, 5'd9, 32'h99);
    drive(3'b001, 3'b001, 1'b0, 1'b0);
    step(); step();
    chk("burst_we", wr_en, 1'b1);
    #2 reset = 1'b1;
    #1 chk("arst_we", wr_en, 1'b0); chk("arst_ready", req_ready, 3'b000);
    m_reset();
    req_valid = '0;
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    drive(3'b111, 3'b000, 1'b0, 1'b0);
    step(); chk("arst_restart", last_ready, 3'b001);

    // Saturate drop_cnt with a long run of x0 writes.
    for (int i = 0; i < N; i++) set_req(i, 5'd0, 32'h0);
    for (int c = 0; c < 270; c++) step();
    chk("drop_sat", drop_cnt, 8'd255);

    // Randomized traffic.
    m_reset();
    reset = 1'b1; #1 reset = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      req_valid = N'($urandom);
      req_lock  = N'($urandom) & N'($urandom);
      stall     = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
